// File: rtl/codes.sv
// Shared instruction codes and types for the execute-stage special-function units.
package codes;

  typedef logic [5:0]  func_t;
  typedef logic [31:0] size_t;

  localparam func_t FUNC_MFHI  = 6'h10;
  localparam func_t FUNC_MTHI  = 6'h11;
  localparam func_t FUNC_MFLO  = 6'h12;
  localparam func_t FUNC_MTLO  = 6'h13;
  localparam func_t FUNC_MULT  = 6'h18;
  localparam func_t FUNC_MULTU = 6'h19;
  localparam func_t FUNC_DIV   = 6'h1A;
  localparam func_t FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV_RUN,
    DIV_FIX
  } muldiv_state_t;

  // Instructions the HI/LO sequencer starts or writes directly.
  function automatic logic is_muldiv_op(func_t f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) ||
           (f == FUNC_DIVU) || (f == FUNC_MTHI) || (f == FUNC_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_unit_divu_iter.sv
// Unsigned radix-2 restoring divider core: load on start, one quotient bit per step.
module divu_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem
);

  logic [W-1:0] div_q;
  logic [W:0]   shifted;
  logic [W:0]   trial;
  logic         fits;

  assign shifted = {rem, quo[W-1]};
  assign trial   = shifted - {1'b0, div_q};
  assign fits    = shifted >= {1'b0, div_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      div_q <= '0;
    end else if (start) begin
      quo   <= dividend;
      rem   <= '0;
      div_q <= divisor;
    end else if (step) begin
      // Remainder stays below the divisor, so the dropped top bit is always zero.
      rem <= fits ? trial[W-1:0] : shifted[W-1:0];
      quo <= {quo[W-2:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner: single-cycle MULT/MULTU, iterative DIV/DIVU, MTHI/MTLO writes,
// and pipeline stall while a result is pending.
module muldiv_unit
  import codes::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  valid_i,
  input  func_t funct_i,
  input  size_t rs_i,
  input  size_t rt_i,
  output size_t hi_o,
  output size_t lo_o,
  output logic  busy_o,
  output logic  done_o,
  output logic  stall_o
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  muldiv_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      hold_q;
  logic             rem_neg_q, quo_neg_q, dz_q;

  logic        accept, is_div, is_sdiv, div_start;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  size_t       abs_rs, abs_rt, quo, rem;

  assign accept    = valid_i && (state_q == IDLE) && is_muldiv_op(funct_i);
  assign is_div    = (funct_i == FUNC_DIV) || (funct_i == FUNC_DIVU);
  assign is_sdiv   = funct_i == FUNC_DIV;
  assign div_start = accept && is_div && (rt_i != '0);

  assign prod_s = $signed(rs_i) * $signed(rt_i);
  assign prod_u = {32'b0, rs_i} * {32'b0, rt_i};
  assign abs_rs = (is_sdiv && rs_i[31]) ? -rs_i : rs_i;
  assign abs_rt = (is_sdiv && rt_i[31]) ? -rt_i : rt_i;

  divu_iter #(.W(32)) u_divu (
    .clk      (clk),
    .rst      (reset),
    .start    (div_start),
    .step     (state_q == DIV_RUN),
    .dividend (abs_rs),
    .divisor  (abs_rt),
    .quo      (quo),
    .rem      (rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && (funct_i == FUNC_MULT || funct_i == FUNC_MULTU)) state_d = MUL;
        else if (accept && is_div) state_d = (rt_i == '0) ? DIV_FIX : DIV_RUN;
      end
      MUL: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      DIV_RUN: begin
        if (cnt_q == CNT_LAST) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = state_q != IDLE;
  assign stall_o = valid_i && busy_o &&
                   (is_muldiv_op(funct_i) || funct_i == FUNC_MFHI || funct_i == FUNC_MFLO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_o      <= '0;
      lo_o      <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      rem_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          case (funct_i)
            FUNC_MTHI:  hi_o   <= rs_i;
            FUNC_MTLO:  lo_o   <= rs_i;
            FUNC_MULT:  hold_q <= prod_s;
            FUNC_MULTU: hold_q <= prod_u;
            default: begin
              // Divide-by-zero result is fixed at accept: HI=rs, LO=all ones.
              hold_q    <= {rs_i, 32'hFFFF_FFFF};
              dz_q      <= rt_i == '0;
              rem_neg_q <= is_sdiv && rs_i[31];
              quo_neg_q <= is_sdiv && (rs_i[31] ^ rt_i[31]);
              cnt_q     <= '0;
            end
          endcase
        end
        MUL:     {hi_o, lo_o} <= hold_q;
        DIV_RUN: cnt_q <= cnt_q + CNT_W'(1);
        DIV_FIX: begin
          if (dz_q) begin
            {hi_o, lo_o} <= hold_q;
          end else begin
            hi_o <= rem_neg_q ? -rem : rem;
            lo_o <= quo_neg_q ? -quo : quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import codes::*;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  valid_i = 1'b0;
  func_t funct_i = '0;
  size_t rs_i = '0;
  size_t rt_i = '0;
  size_t hi_o, lo_o;
  logic  busy_o, done_o, stall_o;

  int errors = 0;
  int checks = 0;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .funct_i (funct_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .stall_o (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input func_t f, input size_t a, input size_t b);
    @(posedge clk); #1;
    valid_i = 1'b1;
    funct_i = f;
    rs_i    = a;
    rt_i    = b;
  endtask

  task automatic run_op(input string tag, input func_t f, input size_t a, input size_t b,
                        input int exp_busy, input size_t exp_hi, input size_t exp_lo);
    int n;
    int dones;
    present(f, a, b);
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 0;
    dones = 0;
    while (busy_o && n < 200) begin
      if (done_o) dones++;
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, " done_pulses"}, 64'(dones), 64'd1);
    check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
  endtask

  initial begin
    int n;
    int cnt;

    #1;
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset busy/done/stall", {61'd0, busy_o, done_o, stall_o}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult",  FUNC_MULT,  32'hFFFF_FFFE, 32'd3,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2", FUNC_DIV, 32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div ovf",  FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

    // Unrelated funct is ignored.
    present(6'h20, 32'd5, 32'd9);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("ignored funct busy", 64'(busy_o), 64'd0);
    check("ignored funct lo", 64'(lo_o), 64'h8000_0000);

    // DIVU with an MFLO held behind it.
    present(FUNC_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    funct_i = FUNC_MFLO;
    n = 0;
    cnt = 0;
    while (busy_o && n < 200) begin
      if (stall_o) cnt++;
      n++;
      @(posedge clk); #1;
    end
    check("divu stall_cycles", 64'(cnt), 64'd33);
    check("divu stall after done", 64'(stall_o), 64'd0);
    check("divu lo", 64'(lo_o), 64'd14);
    check("divu hi", 64'(hi_o), 64'd2);
    valid_i = 1'b0;

    run_op("div by zero", FUNC_DIV, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF);

    present(FUNC_MTHI, 32'hA5A5_A5A5, 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("mthi hi", 64'(hi_o), 64'hA5A5_A5A5);
    check("mthi busy", 64'(busy_o), 64'd0);

    // Asynchronous reset in the middle of a DIVU.
    present(FUNC_DIVU, 32'd1000, 32'd3);
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("divu mid busy", 64'(busy_o), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset busy", 64'(busy_o), 64'd0);
    check("async reset hi", 64'(hi_o), 64'd0);
    check("async reset lo", 64'(lo_o), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      if (done_o || busy_o) cnt++;
      @(posedge clk); #1;
    end
    check("no result after reset", 64'(cnt), 64'd0);
    run_op("mult after reset", FUNC_MULT, 32'd7, 32'd6, 1, 32'd0, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage. MULT/MULTU complete in one busy cycle; DIV/DIVU run an iterative radix-2 restoring divider. It supplies HI/LO to MFHI/MFLO and raises a stall to the pipeline while a result is pending. This takes over HI/LO ownership and stall generation from the ALU.

Parameters:
DIV_ITERS, 32, quotient bits produced by the divider, one per cycle; fixed to the data width.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
valid_i  input  1  execute stage presents an OP_SPECIAL instruction this cycle
funct_i  input  6 (func_t)  function field of the presented instruction
rs_i  input  32 (size_t)  rs operand (dividend / multiplicand / MTHI/MTLO source)
rt_i  input  32 (size_t)  rt operand (divisor / multiplier)
hi_o  output  32 (size_t)  current HI register
lo_o  output  32 (size_t)  current LO register
busy_o  output  1  an operation is in flight
done_o  output  1  one-cycle pulse on the edge that HI/LO take a MULT/DIV result
stall_o  output  1  pipeline must hold the presented instruction

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- On reset: hi_o=0, lo_o=0, busy_o=0, done_o=0, stall_o=0, state=IDLE, iteration counter=0. A reset mid-operation aborts it, and no partial result is written.
- Accept condition: valid_i && state==IDLE && funct_i in {MULT, MULTU, DIV, DIVU, MTHI, MTLO}. Other funct values are ignored.
- MTHI/MTLO: HI (or LO) <= rs_i on the accept edge. Not busy; no done_o.
- States:
  - IDLE
  - MUL: on accept, capture the 64-bit product (signed for MULT, unsigned for MULTU) into a holding register. In MUL: {HI,LO} <= product, done_o=1, return to IDLE. busy_o is high for exactly 1 cycle.
  - DIV_RUN: on accept, latch |rs|, |rt| (raw values for DIVU), the sign of rs, sign(rs)^sign(rt), and counter=0.
    - Each cycle does a restoring step: shift {rem,quo} left 1; trial = rem - divisor; if non-negative, rem=trial and quo[0]=1.
    - The counter increments; after DIV_ITERS steps go to DIV_FIX.
  - DIV_FIX: apply signs (DIV only).
    - LO = quotient, negated if the operand signs differ.
    - HI = remainder, negated if the dividend was negative.
    - Write HI/LO, done_o=1, go to IDLE. DIV/DIVU hold busy_o for exactly DIV_ITERS+1 = 33 cycles.
- Divide by zero (rt_i==0 at accept): skip DIV_RUN and go straight to DIV_FIX with the forced result LO=0xFFFFFFFF, HI=rs_i (both DIV and DIVU). busy_o is high for 1 cycle.
- Signed overflow 0x80000000 / 0xFFFFFFFF: produces LO=0x80000000, HI=0 naturally. No trap.
- stall_o (combinational): valid_i && busy_o && funct_i in {MFHI, MFLO, MULT, MULTU, DIV, DIVU, MTHI, MTLO}. It drops in the cycle after done_o, so an MFHI/MFLO sees the new value.
- Simultaneous events:
  - An instruction presented on the done_o edge is still stalled; it is accepted or read next cycle.
  - A presented instruction is never accepted while busy.
- hi_o/lo_o are register outputs and change only on the accept edge (MTHI/MTLO), on result write, or on reset.

Decomposition:
- Add to package codes: a muldiv_state_t enum (IDLE, MUL, DIV_RUN, DIV_FIX).
- Reuse func_t, size_t and the FUNC_MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO constants from codes.
- One natural sub-module, divu_iter: an unsigned restoring divider core with start, operands, a one-bit-per-cycle step, and quotient/remainder outputs.
- Sign pre-/post-processing and the state machine stay in muldiv_unit.

Test Plan:
1. MULT rs=0xFFFFFFFE, rt=3 -> busy_o 1 cycle, done_o pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy_o exactly 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU 100/7, then hold MFLO on valid_i from the next cycle -> stall_o high through the done_o cycle, low afterwards; lo_o=14, hi_o=2.
5. DIV rs=0x12345678, rt=0 -> 1 busy cycle, LO=0xFFFFFFFF, HI=0x12345678. Then MTHI rs=0xA5A5A5A5 -> hi_o=0xA5A5A5A5 next edge, busy_o stays 0.
6. Start DIVU, assert reset asynchronously mid-cycle at iteration 10 -> busy_o, hi_o, lo_o go to 0 without a clock edge. After release, no done_o occurs and the next MULT runs normally.
